regfile_arbiter: RTL

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/regfile_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// controller state encoding and response codes.
package regfile_arb_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; remembers the last winner so that a
// simultaneous request goes to the other requester next time.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_q = 1 means requester 1 won most recently, so requester 0 is favoured
   logic last_q;
   logic last_d;

   always_comb begin
      gnt = '0;
      if (en) begin
         if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt[1]) begin
         last_d = 1'b1;
      end else if (gnt[0]) begin
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-ported register file with one
// transaction in flight: accept, access, then hold the response until taken.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   localparam int unsigned AW = $clog2(NUM_REGS),
   localparam int unsigned SW = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_valid,
   output logic                  m0_ready,
   input  logic                  m0_we,
   input  logic [AW-1:0]         m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic [SW-1:0]         m0_strb,
   output logic                  m0_rsp_valid,
   input  logic                  m0_rsp_ready,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_resp,

   input  logic                  m1_valid,
   output logic                  m1_ready,
   input  logic                  m1_we,
   input  logic [AW-1:0]         m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic [SW-1:0]         m1_strb,
   output logic                  m1_rsp_valid,
   input  logic                  m1_rsp_ready,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_resp,

   output logic                  rf_wr_en,
   output logic [AW-1:0]         rf_wr_addr,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic [SW-1:0]         rf_wr_strb,
   input  logic [1:0]            rf_wr_resp,
   output logic                  rf_rd_en,
   output logic [AW-1:0]         rf_rd_addr,
   input  logic [DATA_WIDTH-1:0] rf_rd_data
);

   arb_state_e            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         strb_q, strb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;

   logic                  arb_en;
   logic [1:0]            gnt;
   logic                  owner_rsp_ready;

   // Grants are only taken in IDLE, and never while reset is being applied
   assign arb_en = (state_q == ST_IDLE) && !rst;

   rr_arb2 u_rr_arb2 (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req ({m1_valid, m0_valid}),
      .gnt (gnt)
   );

   assign owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      resp_d  = resp_q;

      m0_ready     = 1'b0;
      m1_ready     = 1'b0;
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      m0_rdata     = '0;
      m1_rdata     = '0;
      m0_resp      = RESP_OKAY;
      m1_resp      = RESP_OKAY;
      rf_wr_en     = 1'b0;
      rf_rd_en     = 1'b0;
      rf_wr_addr   = '0;
      rf_rd_addr   = '0;
      rf_wr_data   = '0;
      rf_wr_strb   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               m0_ready = gnt[0];
               m1_ready = gnt[1];
               owner_d  = gnt[1];
               we_d     = gnt[1] ? m1_we    : m0_we;
               addr_d   = gnt[1] ? m1_addr  : m0_addr;
               wdata_d  = gnt[1] ? m1_wdata : m0_wdata;
               strb_d   = gnt[1] ? m1_strb  : m0_strb;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            rf_wr_addr = addr_q;
            rf_rd_addr = addr_q;
            if (we_q) begin
               rf_wr_en   = 1'b1;
               rf_wr_data = wdata_q;
               rf_wr_strb = strb_q;
               rdata_d    = '0;
               resp_d     = rf_wr_resp;
            end else begin
               rf_rd_en = 1'b1;
               rdata_d  = rf_rd_data;
               resp_d   = RESP_OKAY;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (owner_q) begin
               m1_rsp_valid = 1'b1;
               m1_rdata     = rdata_q;
               m1_resp      = resp_q;
            end else begin
               m0_rsp_valid = 1'b1;
               m0_rdata     = rdata_q;
               m0_resp      = resp_q;
            end
            if (owner_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

endmodule
